// File: rtl/digit_pkg.sv
// digit_pkg: state encoding and DigitSupply rail indices shared by the unpacker
package digit_pkg;
   localparam logic COLLECT     = 1'b0;
   localparam logic FULL        = 1'b1;
   localparam int   SUPPLY_LOW  = 0;
   localparam int   SUPPLY_HIGH = 1;
endpackage

// File: rtl/_bit_counter.sv
// _bit_counter: bit position counter for the unpacker; last flags the final bit slot
module _bit_counter import digit_pkg::*; #(
   parameter int OUTPUT_WIDTH = 8
) (
   input  logic                            Clock,
   input  logic                            Reset,
   input  logic [1:0]                      DigitSupply,
   input  logic                            inc,
   input  logic                            clr,
   output logic [$clog2(OUTPUT_WIDTH):0]   count,
   output logic                            last
);
   localparam int CW = $clog2(OUTPUT_WIDTH) + 1;
   logic [CW-1:0] count_q, count_d, zero_v, one_v;
   assign zero_v = {CW{DigitSupply[SUPPLY_LOW]}};
   always_comb begin
      one_v = zero_v;
      one_v[0] = DigitSupply[SUPPLY_HIGH];
      count_d = clr ? zero_v : (inc ? count_q + one_v : count_q);
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) count_q <= zero_v;
      else count_q <= count_d;
   end
   assign count = count_q;
   assign last = count_q == CW'(OUTPUT_WIDTH - 1);
endmodule

// File: rtl/_bit_unpack.sv
// _bit_unpack: serial-to-parallel unpacker, LSB first, valid/ready on both sides
// Option BIT_UNPACK_ALLONES_EN adds allOnes, the AND-reduction of the current word.
module _bit_unpack import digit_pkg::*; #(
   parameter int OUTPUT_WIDTH = 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [1:0]              DigitSupply,
   input  logic                    inputValid,
   input  logic                    inputData,
   output logic                    inputReady,
   output logic                    outputValid,
   output logic [OUTPUT_WIDTH-1:0] outputData,
   input  logic                    outputReady
`ifdef BIT_UNPACK_ALLONES_EN
   ,
   output logic                    allOnes
`endif
);
   localparam int CW = $clog2(OUTPUT_WIDTH) + 1;
   logic lo, hi, full, accept, handoff, last;
   logic state_q, state_d;
   logic [OUTPUT_WIDTH-1:0] data_q, data_d;
   logic [CW-1:0] count;
   assign lo = DigitSupply[SUPPLY_LOW];
   assign hi = DigitSupply[SUPPLY_HIGH];
   assign full = state_q == FULL;
   assign inputReady = Reset ? lo : (full ? outputReady : hi);
   assign accept = inputValid & inputReady;
   assign handoff = full & outputReady;
   assign outputValid = full;
   assign outputData = data_q;
   // In FULL count is 0, so an accept during handoff lands in bit 0 of the next word
   _bit_counter #(.OUTPUT_WIDTH(OUTPUT_WIDTH)) u_cnt (
      .Clock(Clock), .Reset(Reset), .DigitSupply(DigitSupply),
      .inc(accept & ~last), .clr(accept & last), .count(count), .last(last)
   );
   always_comb begin
      data_d = data_q;
      for (int k = 0; k < OUTPUT_WIDTH; k++)
         if (accept && count == CW'(k)) data_d[k] = inputData;
      state_d = (accept & last) | (full & ~handoff);
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= lo;
         data_q  <= {OUTPUT_WIDTH{lo}};
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end
`ifdef BIT_UNPACK_ALLONES_EN
   logic ones_q, ones_d;
   always_comb ones_d = accept ? ((count == {CW{lo}}) ? inputData : ones_q & inputData) : ones_q;
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) ones_q <= hi;
      else ones_q <= ones_d;
   end
   assign allOnes = ones_q;
`endif
endmodule
